// File: rtl/onewire_pkg.sv
// Shared state encoding and timing defaults for the 1-Wire responder.
// us_to_cycles() converts a microsecond figure into clock cycles at a given clock rate.
package onewire_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SLOT,
        RECOVER,
        PRES_WAIT,
        PRES_DRIVE
    } state_t;

    localparam int unsigned DEF_CLK_FREQ     = 100_000_000;
    localparam int unsigned DEF_RESET_MIN_US = 480;
    localparam int unsigned DEF_PRES_WAIT_US = 30;
    localparam int unsigned DEF_PRES_US      = 120;
    localparam int unsigned DEF_SAMPLE_US    = 30;
    localparam int unsigned DEF_HOLD_US      = 30;

    function automatic logic [31:0] us_to_cycles(input int unsigned clk_freq, input int unsigned us);
        return us * (clk_freq / 1_000_000);
    endfunction

endpackage

// File: rtl/onewire_sync_edge.sv
// Two-flop synchroniser for the raw DQ level, plus registered fall/rise strobes
// that are asserted in the same cycle the synchronised level changes.
module onewire_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d_in,
    output logic d_s,
    output logic fall,
    output logic rise
);

    logic s1_q, s2_q;
    logic fall_d, fall_q;
    logic rise_d, rise_q;

    always_comb begin
        fall_d = s2_q & ~s1_q;
        rise_d = ~s2_q & s1_q;
    end

    // An idle 1-Wire bus is pulled high, so the synchroniser resets to 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= 1'b1;
            s2_q   <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            s1_q   <= d_in;
            s2_q   <= s1_q;
            fall_q <= fall_d;
            rise_q <= rise_d;
        end
    end

    assign d_s  = s2_q;
    assign fall = fall_q;
    assign rise = rise_q;

endmodule

// File: rtl/onewire_slave.sv
// 1-Wire responder PHY: reset/presence handling, write-slot deserialiser and
// read-slot serialiser with byte-level valid/ready handshakes.
module onewire_slave
    import onewire_pkg::*;
#(
    parameter int unsigned CLK_FREQ     = DEF_CLK_FREQ,
    parameter int unsigned RESET_MIN_US = DEF_RESET_MIN_US,
    parameter int unsigned PRES_WAIT_US = DEF_PRES_WAIT_US,
    parameter int unsigned PRES_US      = DEF_PRES_US,
    parameter int unsigned SAMPLE_US    = DEF_SAMPLE_US,
    parameter int unsigned HOLD_US      = DEF_HOLD_US
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       dq_in,
    output logic       dq_pull,
    output logic       bus_reset,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    localparam logic [31:0] RESET_CYC = us_to_cycles(CLK_FREQ, RESET_MIN_US);
    localparam logic [31:0] PWAIT_CYC = us_to_cycles(CLK_FREQ, PRES_WAIT_US);
    localparam logic [31:0] PRES_CYC  = us_to_cycles(CLK_FREQ, PRES_US);
    localparam logic [31:0] SAMP_CYC  = us_to_cycles(CLK_FREQ, SAMPLE_US);
    localparam logic [31:0] HOLD_CYC  = us_to_cycles(CLK_FREQ, HOLD_US);

    logic dq_s, dq_fall, dq_rise;

    onewire_sync_edge u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d_in (dq_in),
        .d_s  (dq_s),
        .fall (dq_fall),
        .rise (dq_rise)
    );

    state_t      state_d, state_q;
    logic [31:0] timer_d, timer_q;
    logic [31:0] low_cnt_d, low_cnt_q;
    logic [3:0]  bit_cnt_d, bit_cnt_q;
    logic [7:0]  rx_sr_d, rx_sr_q;
    logic [7:0]  tx_sr_d, tx_sr_q;
    logic        tx_full_d, tx_full_q;
    logic [7:0]  rx_data_d, rx_data_q;
    logic        rx_valid_d, rx_valid_q;
    logic        bus_reset_d, bus_reset_q;
    logic        dq_pull_d, dq_pull_q;

    assign tx_ready = (state_q == IDLE) && (bit_cnt_q == 4'd0) && !tx_full_q;

    always_comb begin
        state_d     = state_q;
        low_cnt_d   = low_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sr_d     = rx_sr_q;
        tx_sr_d     = tx_sr_q;
        tx_full_d   = tx_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        bus_reset_d = 1'b0;

        // Low time only counts the master's drive, never our own pulls.
        if (dq_s)
            low_cnt_d = 32'd0;
        else if (!dq_pull_q && low_cnt_q != RESET_CYC)
            low_cnt_d = low_cnt_q + 32'd1;

        if (tx_valid && tx_ready) begin
            tx_sr_d   = tx_data;
            tx_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: if (dq_fall) state_d = tx_full_d ? SLOT : SAMPLE;
            SAMPLE: if (timer_q == SAMP_CYC - 32'd1) begin
                rx_sr_d   = {dq_s, rx_sr_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                state_d   = RECOVER;
            end
            SLOT: if (timer_q == HOLD_CYC - 32'd1) begin
                tx_sr_d   = {1'b1, tx_sr_q[7:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
                state_d   = RECOVER;
            end
            RECOVER: if (dq_s) begin
                state_d = IDLE;
                if (bit_cnt_q == 4'd8) begin
                    bit_cnt_d = 4'd0;
                    if (tx_full_q) begin
                        tx_full_d = 1'b0;
                    end else begin
                        rx_data_d  = rx_sr_q;
                        rx_valid_d = 1'b1;
                    end
                end
            end
            PRES_WAIT:  if (timer_q == PWAIT_CYC - 32'd1) state_d = PRES_DRIVE;
            PRES_DRIVE: if (timer_q == PRES_CYC - 32'd1)  state_d = RECOVER;
            default:    state_d = IDLE;
        endcase

        // A long low from the master wins over whatever byte was in flight.
        if (dq_rise && low_cnt_q == RESET_CYC) begin
            bus_reset_d = 1'b1;
            state_d     = PRES_WAIT;
            bit_cnt_d   = 4'd0;
            tx_full_d   = 1'b0;
            rx_valid_d  = 1'b0;
            rx_data_d   = rx_data_q;
        end

        if (state_d != state_q || state_d == IDLE || state_d == RECOVER)
            timer_d = 32'd0;
        else
            timer_d = timer_q + 32'd1;

        dq_pull_d = (state_d == PRES_DRIVE) || (state_d == SLOT && !tx_sr_d[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            timer_q     <= 32'd0;
            low_cnt_q   <= 32'd0;
            bit_cnt_q   <= 4'd0;
            rx_sr_q     <= 8'h00;
            tx_sr_q     <= 8'hFF;
            tx_full_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            bus_reset_q <= 1'b0;
            dq_pull_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            low_cnt_q   <= low_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sr_q     <= rx_sr_d;
            tx_sr_q     <= tx_sr_d;
            tx_full_q   <= tx_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            bus_reset_q <= bus_reset_d;
            dq_pull_q   <= dq_pull_d;
        end
    end

    assign dq_pull   = dq_pull_q;
    assign bus_reset = bus_reset_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;

endmodule

// File: tb/tb_onewire_slave.sv
// Bench for onewire_slave: a master BFM on a wired-AND DQ line, scoreboard queues
// for received bytes and returned read bits, one task per scenario.
module tb_onewire_slave;

    localparam int unsigned CLK_FREQ = 4_000_000;
    localparam int C       = 4;      // cycles per microsecond
    localparam int SLOT_US = 70;
    localparam int PW_US   = 30;
    localparam int PRES_US = 120;
    localparam int LIMIT   = 4000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       dq_m = 1'b1;
    logic       dq_in;
    logic       dq_pull, bus_reset, rx_valid, tx_ready;
    logic [7:0] rx_data;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;

    assign dq_in = dq_m & ~dq_pull;

    onewire_slave #(.CLK_FREQ(CLK_FREQ)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .dq_in    (dq_in),
        .dq_pull  (dq_pull),
        .bus_reset(bus_reset),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Monitor-owned event log.
    int         cyc_n = 0;
    int         rx_cnt = 0;
    int         rst_cnt = 0;
    int         rxv_cyc = -1;
    int         acc_cyc = -1;
    logic [7:0] rx_log [0:63];

    // Stimulus-owned expectations.
    logic [7:0] rx_exp [$];
    logic       tx_exp [$];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        if (bus_reset) rst_cnt <= rst_cnt + 1;
        if (rx_valid) begin
            rx_log[rx_cnt[5:0]] <= rx_data;
            rx_cnt  <= rx_cnt + 1;
            rxv_cyc <= cyc_n;
        end
        if (tx_valid && tx_ready) acc_cyc <= cyc_n;
    end

    initial begin
        #900us;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic write_slot(input int low_us);
        dq_m = 1'b0;
        cyc(low_us * C);
        dq_m = 1'b1;
        cyc((low_us < SLOT_US) ? (SLOT_US - low_us) * C : 10 * C);
    endtask

    task automatic write_bit(input logic b);
        write_slot(b ? 6 : 60);
    endtask

    task automatic write_byte(input logic [7:0] v);
        rx_exp.push_back(v);
        for (int i = 0; i < 8; i++) write_bit(v[i]);
        cyc(2);
    endtask

    task automatic read_bit(output logic v);
        dq_m = 1'b0;
        cyc(6 * C);
        dq_m = 1'b1;
        cyc(9 * C);
        v = dq_in;
        cyc((SLOT_US - 15) * C);
    endtask

    task automatic master_reset(input int low_us);
        dq_m = 1'b0;
        cyc(low_us * C);
        dq_m = 1'b1;
    endtask

    task automatic get_presence(output int dly, output int wid);
        dly = 0;
        wid = 0;
        while (!dq_pull && dly < LIMIT) begin cyc(1); dly++; end
        while (dq_pull && wid < LIMIT) begin cyc(1); wid++; end
        cyc(10);
    endtask

    // Eight read slots compared against the bits queued at load time.
    task automatic read_slots();
        logic got, want;
        for (int i = 0; i < 8; i++) begin
            read_bit(got);
            want = (tx_exp.size() > 0) ? tx_exp.pop_front() : 1'bx;
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL read_bit%0d got=%b exp=%b", i, got, want);
            end
            checks++;
            if (tx_ready !== (i == 7)) begin
                errors++;
                $display("FAIL tx_ready_slot%0d got=%b exp=%b", i, tx_ready, (i == 7));
            end
        end
    endtask

    task automatic test_reset();
        cyc(3);
        checks++; if (dq_pull !== 1'b0)   begin errors++; $display("FAIL rst_dq_pull got=%b exp=0", dq_pull); end
        checks++; if (bus_reset !== 1'b0) begin errors++; $display("FAIL rst_bus_reset got=%b exp=0", bus_reset); end
        checks++; if (rx_data !== 8'h00)  begin errors++; $display("FAIL rst_rx_data got=%h exp=00", rx_data); end
        checks++; if (rx_valid !== 1'b0)  begin errors++; $display("FAIL rst_rx_valid got=%b exp=0", rx_valid); end
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_tx_ready got=%b exp=1", tx_ready); end
        rst_n = 1'b1;
        cyc(5);
        checks++; if (tx_ready !== 1'b1)  begin errors++; $display("FAIL post_rst_tx_ready got=%b exp=1", tx_ready); end
    endtask

    task automatic test_presence();
        int r0, dly, wid;
        r0 = rst_cnt;
        master_reset(500);
        get_presence(dly, wid);
        checks++;
        if (rst_cnt !== r0 + 1) begin errors++; $display("FAIL pres_bus_reset got=%0d exp=%0d", rst_cnt - r0, 1); end
        // 2-cycle synchroniser plus one registered strobe ahead of the wait.
        checks++;
        if (dly < PW_US * C + 1 || dly > PW_US * C + 5) begin
            errors++; $display("FAIL pres_delay got=%0d exp=%0d", dly, PW_US * C + 3);
        end
        checks++;
        if (wid < PRES_US * C - 2 || wid > PRES_US * C + 2) begin
            errors++; $display("FAIL pres_width got=%0d exp=%0d", wid, PRES_US * C);
        end
    endtask

    task automatic test_write();
        int n0;
        logic [7:0] want;
        n0 = rx_cnt;
        write_byte(8'hA5);
        want = rx_exp.pop_front();
        checks++; if (rx_cnt !== n0 + 1) begin errors++; $display("FAIL write_rx_count got=%0d exp=1", rx_cnt - n0); end
        checks++; if (rx_log[n0[5:0]] !== want) begin errors++; $display("FAIL write_rx_data got=%h exp=%h", rx_log[n0[5:0]], want); end
    endtask

    task automatic test_read();
        int n;
        logic [7:0] v;
        v = 8'h3C;
        n = 0;
        while (!tx_ready && n < LIMIT) begin cyc(1); n++; end
        tx_data  = v;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) tx_exp.push_back(v[i]);
        cyc(1);
        tx_valid = 1'b0;
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL read_load_ready got=%b exp=0", tx_ready); end
        read_slots();
    endtask

    task automatic test_long_slot();
        int r0, n0;
        logic [7:0] v, want;
        v  = 8'h5A;
        r0 = rst_cnt;
        n0 = rx_cnt;
        rx_exp.push_back(v);
        write_slot(200);
        for (int i = 1; i < 8; i++) write_bit(v[i]);
        cyc(2);
        want = rx_exp.pop_front();
        checks++; if (rst_cnt !== r0) begin errors++; $display("FAIL long_slot_reset got=%0d exp=0", rst_cnt - r0); end
        checks++; if (rx_cnt !== n0 + 1) begin errors++; $display("FAIL long_slot_count got=%0d exp=1", rx_cnt - n0); end
        checks++; if (rx_log[n0[5:0]] !== want) begin errors++; $display("FAIL long_slot_data got=%h exp=%h", rx_log[n0[5:0]], want); end
    endtask

    task automatic test_abort();
        int r0, n0, dly, wid;
        logic [7:0] want;
        r0 = rst_cnt;
        n0 = rx_cnt;
        write_bit(1'b1);
        write_bit(1'b0);
        write_bit(1'b1);
        master_reset(480);
        get_presence(dly, wid);
        checks++; if (rst_cnt !== r0 + 1) begin errors++; $display("FAIL abort_reset got=%0d exp=1", rst_cnt - r0); end
        checks++; if (rx_cnt !== n0) begin errors++; $display("FAIL abort_rx_valid got=%0d exp=0", rx_cnt - n0); end
        write_byte(8'hC3);
        want = rx_exp.pop_front();
        checks++; if (rx_cnt !== n0 + 1) begin errors++; $display("FAIL abort_next_count got=%0d exp=1", rx_cnt - n0); end
        checks++; if (rx_log[n0[5:0]] !== want) begin errors++; $display("FAIL abort_next_data got=%h exp=%h", rx_log[n0[5:0]], want); end
    endtask

    task automatic test_tx_holdoff();
        int n0, a0;
        logic [7:0] v, t, want;
        v  = 8'h96;
        t  = 8'h11;
        n0 = rx_cnt;
        a0 = acc_cyc;
        rx_exp.push_back(v);
        for (int i = 0; i < 3; i++) write_bit(v[i]);
        tx_data  = t;
        tx_valid = 1'b1;
        for (int i = 0; i < 8; i++) tx_exp.push_back(t[i]);
        for (int i = 3; i < 8; i++) begin
            write_bit(v[i]);
            if (i < 7) begin
                checks++;
                if (acc_cyc !== a0) begin errors++; $display("FAIL holdoff_early_accept got=%0d exp=%0d", acc_cyc, a0); end
            end
        end
        tx_valid = 1'b0;
        want = rx_exp.pop_front();
        checks++; if (rx_log[n0[5:0]] !== want) begin errors++; $display("FAIL holdoff_rx_data got=%h exp=%h", rx_log[n0[5:0]], want); end
        checks++;
        if (acc_cyc - rxv_cyc < 0 || acc_cyc - rxv_cyc > 1) begin
            errors++; $display("FAIL holdoff_accept_cycle got=%0d exp=0..1", acc_cyc - rxv_cyc);
        end
        read_slots();
    endtask

    task automatic test_async_reset();
        int n, n0;
        logic [7:0] want;
        master_reset(500);
        n = 0;
        while (!dq_pull && n < LIMIT) begin cyc(1); n++; end
        checks++; if (dq_pull !== 1'b1) begin errors++; $display("FAIL arst_pres_start got=%b exp=1", dq_pull); end
        cyc(PRES_US * C / 2);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (dq_pull !== 1'b0) begin errors++; $display("FAIL arst_dq_pull got=%b exp=0", dq_pull); end
        cyc(2);
        rst_n = 1'b1;
        cyc(5);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL arst_tx_ready got=%b exp=1", tx_ready); end
        checks++; if (dq_pull !== 1'b0)  begin errors++; $display("FAIL arst_release_pull got=%b exp=0", dq_pull); end
        n0 = rx_cnt;
        write_byte(8'h01);
        want = rx_exp.pop_front();
        checks++; if (rx_log[n0[5:0]] !== want) begin errors++; $display("FAIL arst_next_data got=%h exp=%h", rx_log[n0[5:0]], want); end
    endtask

    initial begin
        test_reset();
        test_presence();
        test_write();
        test_read();
        test_long_slot();
        test_abort();
        test_tx_holdoff();
        test_async_reset();
        checks++; if (rx_exp.size() != 0) begin errors++; $display("FAIL rx_queue_left got=%0d exp=0", rx_exp.size()); end
        checks++; if (tx_exp.size() != 0) begin errors++; $display("FAIL tx_queue_left got=%0d exp=0", tx_exp.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
